// File: rtl/musicbox_keys_pkg.sv
// Shared key-scanner definitions: key counts and the mode-key index encoding.
package musicbox_keys_pkg;

  localparam int NUM_MUSIC_KEYS = 6;
  localparam int NUM_MODE_KEYS  = 5;

  typedef enum logic [2:0] {
    MK_SONG0   = 3'd0,
    MK_SONG1   = 3'd1,
    MK_MAKEREC = 3'd2,
    MK_PLAYREC = 3'd3,
    MK_BEE     = 3'd4
  } mode_key_e;

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchroniser, polarity normalisation, tick-driven
// debounce counter, accepted level and registered press/release pulses.
module key_debounce_channel #(
  parameter int DEBOUNCE_TICKS   = 20,
  parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pin_raw,
  output logic level,
  output logic press,
  output logic rel
);

  // Synchroniser resets to the pin's released level so reset never looks like a press.
  localparam logic       IDLE_RAW = INPUT_ACTIVE_LOW;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic       sample;

  assign sample = sync2_q ^ INPUT_ACTIVE_LOW;

  // Next-state: synchroniser shift and debounce decision on each tick.
  always_comb begin
    sync1_d  = pin_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    if (tick) begin
      if (sample == stable_q) begin
        cnt_d = 8'd0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sample;
        cnt_d    = 8'd0;
        press_d  = sample;
        rel_d    = ~sample;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // State registers; pulses land in the same cycle as the level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= IDLE_RAW;
      sync2_q  <= IDLE_RAW;
      stable_q <= 1'b0;
      cnt_q    <= 8'd0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/key_input_scanner.sv
// Key input scanner: sample-tick prescaler, 11 debounced key channels and a
// lowest-index-wins mode-key event. Optional long-press detection on the mode
// keys is built only when KEYIN_LONGPRESS_EN is defined; otherwise
// modeKey_longPress is tied low.
module key_input_scanner
  import musicbox_keys_pkg::*;
#(
  parameter int PRESCALE_DIV     = 50000,
  parameter int DEBOUNCE_TICKS   = 20,
  parameter bit INPUT_ACTIVE_LOW = 1'b1,
  parameter int LONGPRESS_TICKS  = 1000
) (
  input  logic                      CLK_50Mhz,
  input  logic                      reset_n,
  input  logic [NUM_MUSIC_KEYS-1:0] max10Board_GPIO_Input_MusicKeys,
  input  logic [NUM_MODE_KEYS-1:0]  max10Board_GPIO_Input_ModeKeys,
  output logic [NUM_MUSIC_KEYS-1:0] output_MusicKey,
  output logic [NUM_MUSIC_KEYS-1:0] output_MusicKey_press,
  output logic [NUM_MUSIC_KEYS-1:0] output_MusicKey_release,
  output logic [NUM_MODE_KEYS-1:0]  output_ModeKey,
  output logic                      modeKey_valid,
  output logic [2:0]                modeKey_index,
  output logic [NUM_MODE_KEYS-1:0]  modeKey_longPress
);

  localparam int NUM_KEYS = NUM_MUSIC_KEYS + NUM_MODE_KEYS;
  localparam int PS_W     = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0]          ps_q, ps_d;
  logic                     tick;
  logic [NUM_KEYS-1:0]      raw_all, lvl_all, press_all, rel_all;
  logic [NUM_MODE_KEYS-1:0] mode_lvl, mode_press;
  mode_key_e                mode_idx;

  assign tick = (ps_q == PS_LAST);

  // Prescaler next count: wraps to 0 on the tick cycle.
  always_comb begin
    ps_d = tick ? '0 : ps_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) ps_q <= '0;
    else          ps_q <= ps_d;
  end

  assign raw_all = {max10Board_GPIO_Input_ModeKeys, max10Board_GPIO_Input_MusicKeys};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
      .INPUT_ACTIVE_LOW(INPUT_ACTIVE_LOW)
    ) u_chan (
      .clk    (CLK_50Mhz),
      .rst_n  (reset_n),
      .tick   (tick),
      .pin_raw(raw_all[g]),
      .level  (lvl_all[g]),
      .press  (press_all[g]),
      .rel    (rel_all[g])
    );
  end

  assign output_MusicKey         = lvl_all[NUM_MUSIC_KEYS-1:0];
  assign output_MusicKey_press   = press_all[NUM_MUSIC_KEYS-1:0];
  assign output_MusicKey_release = rel_all[NUM_MUSIC_KEYS-1:0];
  assign mode_lvl                = lvl_all[NUM_KEYS-1:NUM_MUSIC_KEYS];
  assign mode_press              = press_all[NUM_KEYS-1:NUM_MUSIC_KEYS];
  assign output_ModeKey          = mode_lvl;

  // Priority encode simultaneous mode presses; the lowest index wins.
  always_comb begin
    mode_idx = MK_SONG0;
    for (int i = NUM_MODE_KEYS - 1; i >= 0; i--) begin
      if (mode_press[i]) mode_idx = mode_key_e'(i[2:0]);
    end
  end

  assign modeKey_valid = |mode_press;
  assign modeKey_index = mode_idx;

`ifdef KEYIN_LONGPRESS_EN
  localparam logic [9:0] LP_TARGET = 10'(LONGPRESS_TICKS);

  logic [NUM_MODE_KEYS-1:0][9:0] hold_q, hold_d;
  logic [NUM_MODE_KEYS-1:0]      lp_q, lp_d;

  // Hold counters: count ticks while pressed, saturate, clear on release;
  // the pulse fires only on the tick that lands exactly on the target.
  always_comb begin
    hold_d = hold_q;
    lp_d   = '0;
    for (int i = 0; i < NUM_MODE_KEYS; i++) begin
      if (!mode_lvl[i]) begin
        hold_d[i] = 10'd0;
      end else if (tick && (hold_q[i] != 10'h3FF)) begin
        hold_d[i] = hold_q[i] + 10'd1;
        lp_d[i]   = ((hold_q[i] + 10'd1) == LP_TARGET);
      end
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      lp_q   <= '0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end
  end

  assign modeKey_longPress = lp_q;
`else
  assign modeKey_longPress = '0;
`endif

endmodule

// File: tb/tb_key_input_scanner.sv
// Scoreboard bench for key_input_scanner with PRESCALE_DIV=4, DEBOUNCE_TICKS=3.
// Stimulus pushes expected events (with a cycle window); the monitor pops one
// whenever the DUT raises any pulse output.
module tb_key_input_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] music_pins;
  logic [4:0] mode_pins;
  logic [5:0] music_lvl, music_press, music_rel;
  logic [4:0] mode_lvl, mode_long;
  logic       mode_valid;
  logic [2:0] mode_index;
  logic [31:0] all_out;

  always #5 clk = ~clk;

  key_input_scanner #(
    .PRESCALE_DIV    (4),
    .DEBOUNCE_TICKS  (3),
    .INPUT_ACTIVE_LOW(1'b1),
    .LONGPRESS_TICKS (10)
  ) dut (
    .CLK_50Mhz                      (clk),
    .reset_n                        (rst_n),
    .max10Board_GPIO_Input_MusicKeys(music_pins),
    .max10Board_GPIO_Input_ModeKeys (mode_pins),
    .output_MusicKey                (music_lvl),
    .output_MusicKey_press          (music_press),
    .output_MusicKey_release        (music_rel),
    .output_ModeKey                 (mode_lvl),
    .modeKey_valid                  (mode_valid),
    .modeKey_index                  (mode_index),
    .modeKey_longPress              (mode_long)
  );

  assign all_out = {music_lvl, music_press, music_rel, mode_lvl, mode_valid, mode_index, mode_long};

  typedef struct {
    logic [5:0] mp;
    logic [5:0] mr;
    logic       mv;
    logic [2:0] mi;
    logic [4:0] lp;
    logic [5:0] ml;
    logic [4:0] dl;
    int         lo;
    int         hi;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  ok;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse output is an event that must match the queue head.
  always @(negedge clk) begin
    if (rst_n && ((|music_press) || (|music_rel) || mode_valid || (|mode_long))) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got press=%b release=%b mvalid=%b idx=%0d long=%b at cycle %0d, required no event",
                 music_press, music_rel, mode_valid, mode_index, mode_long, cyc);
      end else begin
        mon_e = q.pop_front();
        ok = (music_press == mon_e.mp) && (music_rel == mon_e.mr) &&
             (mode_valid == mon_e.mv) && (!mon_e.mv || (mode_index == mon_e.mi)) &&
             (mode_long == mon_e.lp) && (music_lvl == mon_e.ml) && (mode_lvl == mon_e.dl) &&
             (cyc >= mon_e.lo) && (cyc <= mon_e.hi);
        if (!ok) begin
          bad++;
          $display("FAIL event_check: got press=%b rel=%b mv=%b idx=%0d long=%b lvl=%b mode=%b cyc=%0d; required press=%b rel=%b mv=%b idx=%0d long=%b lvl=%b mode=%b cyc=%0d..%0d",
                   music_press, music_rel, mode_valid, mode_index, mode_long, music_lvl, mode_lvl, cyc,
                   mon_e.mp, mon_e.mr, mon_e.mv, mon_e.mi, mon_e.lp, mon_e.ml, mon_e.dl, mon_e.lo, mon_e.hi);
        end
      end
    end
  end

  task automatic expect_ev(input logic [5:0] mp, input logic [5:0] mr, input logic mv,
                           input logic [2:0] mi, input logic [4:0] lp, input logic [5:0] ml,
                           input logic [4:0] dl, input int lo, input int hi);
    ev_t e;
    e.mp = mp; e.mr = mr; e.mv = mv; e.mi = mi; e.lp = lp;
    e.ml = ml; e.dl = dl; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for all queued events, then idle to catch stray pulses.
  task automatic drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending events, required 0", name, q.size());
      q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  int c;

  initial begin
    music_pins = '1;
    mode_pins  = '1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (4) @(negedge clk);
      chk("reset_idle", all_out, 32'd0);
    end

    // Clean press / release of music key 2.
    @(negedge clk);
    music_pins[2] = 1'b0; c = cyc;
    expect_ev(6'b000100, 6'b0, 1'b0, 3'd0, 5'b0, 6'b000100, 5'b0, c + 11, c + 14);
    drain("clean_press", 40);
    chk("press_level", {26'd0, music_lvl}, 32'b000100);
    music_pins[2] = 1'b1; c = cyc;
    expect_ev(6'b0, 6'b000100, 1'b0, 3'd0, 5'b0, 6'b0, 5'b0, c + 11, c + 14);
    drain("clean_release", 40);

    // Bounce on key 0: two ticks low, one tick high, then steady low.
    music_pins[0] = 1'b0;
    repeat (8) @(negedge clk);
    music_pins[0] = 1'b1;
    repeat (4) @(negedge clk);
    music_pins[0] = 1'b0; c = cyc;
    expect_ev(6'b000001, 6'b0, 1'b0, 3'd0, 5'b0, 6'b000001, 5'b0, c + 11, c + 14);
    drain("bounce_press", 40);
    music_pins[0] = 1'b1; c = cyc;
    expect_ev(6'b0, 6'b000001, 1'b0, 3'd0, 5'b0, 6'b0, 5'b0, c + 11, c + 14);
    drain("bounce_release", 40);

    // Simultaneous music keys 1 and 5.
    music_pins[1] = 1'b0; music_pins[5] = 1'b0; c = cyc;
    expect_ev(6'b100010, 6'b0, 1'b0, 3'd0, 5'b0, 6'b100010, 5'b0, c + 11, c + 14);
    drain("multi_press", 40);
    music_pins = '1; c = cyc;
    expect_ev(6'b0, 6'b100010, 1'b0, 3'd0, 5'b0, 6'b0, 5'b0, c + 11, c + 14);
    drain("multi_release", 40);

    // Simultaneous mode keys 3 and 1: lowest index reported.
    mode_pins[3] = 1'b0; mode_pins[1] = 1'b0; c = cyc;
    expect_ev(6'b0, 6'b0, 1'b1, 3'd1, 5'b0, 6'b0, 5'b01010, c + 11, c + 14);
    drain("mode_pair", 40);
    chk("mode_pair_level", {27'd0, mode_lvl}, 32'b01010);
    mode_pins = '1;
    repeat (20) @(negedge clk);
    chk("mode_release_level", {27'd0, mode_lvl}, 32'd0);

    // Single mode key 2.
    mode_pins[2] = 1'b0; c = cyc;
    expect_ev(6'b0, 6'b0, 1'b1, 3'd2, 5'b0, 6'b0, 5'b00100, c + 11, c + 14);
    drain("mode_single", 40);
    mode_pins = '1;
    repeat (20) @(negedge clk);
    chk("mode_single_release", {27'd0, mode_lvl}, 32'd0);

    // Reset mid-debounce on music key 4; prescaler restarts so timing is exact.
    music_pins[4] = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_mid_outputs", all_out, 32'd0);
    rst_n = 1'b1; c = cyc;
    expect_ev(6'b010000, 6'b0, 1'b0, 3'd0, 5'b0, 6'b010000, 5'b0, c + 12, c + 12);
    drain("reset_mid_press", 40);
    music_pins[4] = 1'b1; c = cyc;
    expect_ev(6'b0, 6'b010000, 1'b0, 3'd0, 5'b0, 6'b0, 5'b0, c + 11, c + 14);
    drain("reset_mid_release", 40);

    // Long hold of mode key 4 (Bee).
    mode_pins[4] = 1'b0; c = cyc;
    expect_ev(6'b0, 6'b0, 1'b1, 3'd4, 5'b0, 6'b0, 5'b10000, c + 11, c + 14);
`ifdef KEYIN_LONGPRESS_EN
    expect_ev(6'b0, 6'b0, 1'b0, 3'd0, 5'b10000, 6'b0, 5'b10000, c + 51, c + 54);
`endif
    drain("long_hold", 100);
    repeat (80) @(negedge clk);
    chk("long_hold_level", {27'd0, mode_lvl}, 32'b10000);
    mode_pins = '1;
    repeat (30) @(negedge clk);
    chk("long_release_level", {27'd0, mode_lvl}, 32'd0);

    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
